ripple_count_ctrl: RTL and testbench

//  Sequencer for an asynchronous ripple event counter. Per measurement it:
//  - clears the counter through its reset;
//  - opens a clock-gate window so events can reach the counter;
//  - closes the window and waits for ripple settling;
//  - samples the counter output and presents the count on a valid/ready handshake.

---
 rtl/ripple_count_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl.sv
// Sequencer for an asynchronous ripple event counter: clear, gate window, settle, capture, handshake.
// Optional continuous re-measurement loop is enabled with `define RCC_CONTINUOUS_EN (adds cont_mode).
module ripple_count_ctrl #(
  parameter int unsigned WID_COUNT  = 6,
  parameter int unsigned WID_WIN    = 16,
  parameter int unsigned CLR_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WID_WIN-1:0]   win_len,
`ifdef RCC_CONTINUOUS_EN
  input  logic                 cont_mode,
`endif
  output logic                 busy,
  output logic                 cnt_rst_n,
  output logic                 gate_en,
  input  logic [WID_COUNT-1:0] cnt_result,
  output logic [WID_COUNT-1:0] count,
  output logic                 count_valid,
  input  logic                 count_ready
);

  localparam int unsigned CYC_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e               state_q,       state_d;
  logic [CYC_W-1:0]     cyc_q,         cyc_d;
  logic [WID_WIN-1:0]   win_q,         win_d;
  logic [WID_WIN-1:0]   win_cnt_q,     win_cnt_d;
  logic                 busy_q,        busy_d;
  logic                 cnt_rst_n_q,   cnt_rst_n_d;
  logic                 gate_en_q,     gate_en_d;
  logic [WID_COUNT-1:0] count_q,       count_d;
  logic                 count_valid_q, count_valid_d;

  // Next-state and next-output logic; every output is a flop.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    win_d         = win_q;
    win_cnt_d     = win_cnt_q;
    busy_d        = busy_q;
    cnt_rst_n_d   = cnt_rst_n_q;
    gate_en_d     = gate_en_q;
    count_d       = count_q;
    count_valid_d = count_valid_q;

    case (state_q)
      S_IDLE: begin
        cnt_rst_n_d = 1'b0;
        gate_en_d   = 1'b0;
        if (start) begin
          win_d   = win_len;
          busy_d  = 1'b1;
          // From IDLE the clear phase also spans the accept cycle.
          cyc_d   = CYC_W'(CLR_CYC);
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        count_valid_d = 1'b0;
        if (cyc_q == '0) begin
          cnt_rst_n_d = 1'b1;
          if (win_q == '0) begin
            cyc_d   = CYC_W'(SETTLE_CYC - 1);
            state_d = S_SETTLE;
          end else begin
            gate_en_d = 1'b1;
            win_cnt_d = win_q;
            state_d   = S_GATE;
          end
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end

      S_GATE: begin
        win_cnt_d = win_cnt_q - WID_WIN'(1);
        if (win_cnt_q == WID_WIN'(1)) begin
          gate_en_d = 1'b0;
          cyc_d     = CYC_W'(SETTLE_CYC - 1);
          state_d   = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cyc_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end

      S_CAPTURE: begin
        // Counter taps are inverted Q: cleared counter reads all-ones.
        count_d       = ~cnt_result;
        count_valid_d = 1'b1;
        state_d       = S_HOLD;
`ifdef RCC_CONTINUOUS_EN
        if (cont_mode) begin
          cnt_rst_n_d = 1'b0;
          cyc_d       = CYC_W'(CLR_CYC - 1);
          state_d     = S_CLEAR;
        end
`endif
      end

      S_HOLD: begin
        if (count_ready) begin
          count_valid_d = 1'b0;
          busy_d        = 1'b0;
          cnt_rst_n_d   = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cyc_q         <= '0;
      win_q         <= '0;
      win_cnt_q     <= '0;
      busy_q        <= 1'b0;
      cnt_rst_n_q   <= 1'b0;
      gate_en_q     <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      win_q         <= win_d;
      win_cnt_q     <= win_cnt_d;
      busy_q        <= busy_d;
      cnt_rst_n_q   <= cnt_rst_n_d;
      gate_en_q     <= gate_en_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign busy        = busy_q;
  assign cnt_rst_n   = cnt_rst_n_q;
  assign gate_en     = gate_en_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Directed bench for ripple_count_ctrl with a behavioural ripple counter on the event side.
module tb_ripple_count_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] win_len;
  logic        busy;
  logic        cnt_rst_n;
  logic        gate_en;
  logic [5:0]  cnt_result;
  logic [5:0]  count;
  logic        count_valid;
  logic        count_ready;
`ifdef RCC_CONTINUOUS_EN
  logic        cont_mode;
`endif

  logic        ev_fast;
  logic        ev_ph = 1'b0;
  logic [5:0]  ev_q;

  int n_cmp  = 0;
  int n_fail = 0;

  ripple_count_ctrl #(
    .WID_COUNT (6),
    .WID_WIN   (16),
    .CLR_CYC   (2),
    .SETTLE_CYC(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .win_len    (win_len),
`ifdef RCC_CONTINUOUS_EN
    .cont_mode  (cont_mode),
`endif
    .busy       (busy),
    .cnt_rst_n  (cnt_rst_n),
    .gate_en    (gate_en),
    .cnt_result (cnt_result),
    .count      (count),
    .count_valid(count_valid),
    .count_ready(count_ready)
  );

  always #5 clk = ~clk;

  // Event source: one event per clk (fast) or per two clks, on the falling edge.
  always @(negedge clk) ev_ph <= ~ev_ph;

  always @(negedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) ev_q <= '0;
    else if (gate_en && (ev_fast || ev_ph)) ev_q <= ev_q + 6'd1;
  end

  assign cnt_result = ~ev_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one measurement; returns edges from accept to count_valid and gate-high cycles.
  task automatic meas(input logic [15:0] w, output int lat, output int gcyc, output logic b0);
    @(negedge clk);
    win_len = w;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    b0    = busy;
    lat   = 0;
    gcyc  = 0;
    while (!count_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (gate_en) gcyc++;
    end
  endtask

  task automatic handshake(input logic [5:0] exp_cnt);
    @(negedge clk);
    count_ready = 1'b1;
    @(posedge clk);
    #1;
    count_ready = 1'b0;
    check("hs_valid", 32'(count_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    check("hs_count_kept", 32'(count), 32'(exp_cnt));
  endtask

  initial begin
    int   lat;
    int   gcyc;
    logic b0;

    rst_n       = 1'b0;
    start       = 1'b0;
    win_len     = '0;
    count_ready = 1'b0;
    ev_fast     = 1'b0;
`ifdef RCC_CONTINUOUS_EN
    cont_mode   = 1'b0;
`endif

    // Reset values
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gate_en", 32'(gate_en), 32'd0);
    check("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single measurement, events at clk/2
    meas(16'd10, lat, gcyc, b0);
    check("m10_busy", 32'(b0), 32'd1);
    check("m10_latency", 32'(lat), 32'd18);
    check("m10_gate_cycles", 32'(gcyc), 32'd10);
    check("m10_count", 32'(count), 32'd5);
    handshake(6'd5);

    // Zero window with backpressure and ignored start pulses
    meas(16'd0, lat, gcyc, b0);
    check("m0_latency", 32'(lat), 32'd8);
    check("m0_gate_cycles", 32'(gcyc), 32'd0);
    check("m0_count", 32'(count), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 5 || i == 12);
      @(posedge clk);
      #1;
      check("bp_valid", 32'(count_valid), 32'd1);
      check("bp_count", 32'(count), 32'd0);
    end
    start = 1'b0;
    check("bp_busy", 32'(busy), 32'd1);
    // start coincident with ready acceptance must be ignored
    @(negedge clk);
    start       = 1'b1;
    count_ready = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    count_ready = 1'b0;
    check("coinc_busy", 32'(busy), 32'd0);
    check("coinc_valid", 32'(count_valid), 32'd0);
    @(posedge clk);
    #1;
    check("coinc_busy_after", 32'(busy), 32'd0);

    // Wrap: 70 events into a 6-bit counter
    ev_fast = 1'b1;
    meas(16'd70, lat, gcyc, b0);
    check("m70_latency", 32'(lat), 32'd78);
    check("m70_gate_cycles", 32'(gcyc), 32'd70);
    check("m70_count", 32'(count), 32'd6);
    handshake(6'd6);

    // Reset in the middle of GATE
    @(negedge clk);
    win_len = 16'd20;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre_rst_gate_en", 32'(gate_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_gate_en", 32'(gate_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    meas(16'd7, lat, gcyc, b0);
    check("m7_latency", 32'(lat), 32'd15);
    check("m7_gate_cycles", 32'(gcyc), 32'd7);
    check("m7_count", 32'(count), 32'd7);
    handshake(6'd7);

`ifdef RCC_CONTINUOUS_EN
    // Continuous mode: pulses every 2+3+4+1 = 10 cycles
    cont_mode = 1'b1;
    meas(16'd3, lat, gcyc, b0);
    check("c_first_latency", 32'(lat), 32'd11);
    check("c_first_count", 32'(count), 32'd3);
    @(posedge clk);
    #1;
    check("c_pulse_drop", 32'(count_valid), 32'd0);
    lat = 1;
    while (!count_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("c_period", 32'(lat), 32'd10);
    check("c_second_count", 32'(count), 32'd3);
    check("c_busy_loop", 32'(busy), 32'd1);
    cont_mode = 1'b0;
    @(posedge clk);
    #1;
    lat = 1;
    while (!count_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("c_final_period", 32'(lat), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check("c_final_held", 32'(count_valid), 32'd1);
    check("c_final_count", 32'(count), 32'd3);
    handshake(6'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
